// File: rtl/psum_accum_pkg.sv
// psum_accum_pkg: shared FSM state encoding and err_o bit indices for the partial-sum accumulator.
package psum_accum_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } acc_state_e;

    localparam int ERR_SKEW = 0;
    localparam int ERR_OVF  = 1;
    localparam int ERR_DROP = 2;
    localparam int ERR_W    = 3;
endpackage

// File: rtl/psum_accum_deskew.sv
// psum_deskew: realigns skewed systolic lanes and flags partially aligned rows.
//   clk, rst_n      : clock, async active-low reset (clears the delay lines)
//   psum_row_i      : skewed lane data, lane k arriving k cycles after lane 0
//   psum_en_row_i   : per-lane valid travelling with the data
//   row_o           : aligned row (combinational from the delay-line tails)
//   valid_o         : every lane of the aligned row is valid
//   skew_err_o      : some, but not all, lanes are valid
module psum_deskew
    import psum_accum_pkg::*;
#(
    parameter int PE_SIZE    = 2,
    parameter int PSUM_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PSUM_WIDTH*PE_SIZE-1:0] psum_row_i,
    input  logic [PE_SIZE-1:0]            psum_en_row_i,
    output logic [PSUM_WIDTH*PE_SIZE-1:0] row_o,
    output logic                          valid_o,
    output logic                          skew_err_o
);
    logic [PE_SIZE-1:0] en_w;

    for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
        localparam int DLY = PE_SIZE - 1 - k;
        if (DLY == 0) begin : g_pass
            assign row_o[PSUM_WIDTH*k +: PSUM_WIDTH] = psum_row_i[PSUM_WIDTH*k +: PSUM_WIDTH];
            assign en_w[k] = psum_en_row_i[k];
        end else begin : g_dly
            // Enable rides in the top bit so data and valid can never drift apart.
            logic [PSUM_WIDTH:0] sr_q [DLY];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DLY; i++) sr_q[i] <= '0;
                end else begin
                    sr_q[0] <= {psum_en_row_i[k], psum_row_i[PSUM_WIDTH*k +: PSUM_WIDTH]};
                    for (int i = 1; i < DLY; i++) sr_q[i] <= sr_q[i-1];
                end
            end
            assign {en_w[k], row_o[PSUM_WIDTH*k +: PSUM_WIDTH]} = sr_q[DLY-1];
        end
    end

    assign valid_o    = &en_w;
    assign skew_err_o = |en_w && !(&en_w);
endmodule

// File: rtl/psum_accum.sv
// psum_accum: de-skews systolic partial sums, accumulates tiles into a row buffer and drains results.
//   clk, rst_n       : clock, async active-low reset
//   psum_row_i       : skewed partial sums, lane k in bits [PSUM_WIDTH*(k+1)-1 : PSUM_WIDTH*k]
//   psum_en_row_i    : per-lane valid
//   start_i          : tile-start pulse, honoured only in IDLE
//   first_i, last_i  : overwrite instead of add / drain after this tile (sampled with start_i)
//   rows_i           : rows in the tile, 1..ACC_DEPTH (sampled with start_i)
//   out_data_o       : result row, same lane packing
//   out_valid_o      : result row valid; out_ready_i accepts it
//   busy_o           : FSM is not IDLE
//   err_o            : sticky {row dropped, signed overflow, skew mismatch}
module psum_accum
    import psum_accum_pkg::*;
#(
    parameter int PE_SIZE    = 2,
    parameter int PSUM_WIDTH = 32,
    parameter int ACC_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [PSUM_WIDTH*PE_SIZE-1:0]  psum_row_i,
    input  logic [PE_SIZE-1:0]             psum_en_row_i,
    input  logic                           start_i,
    input  logic                           first_i,
    input  logic                           last_i,
    input  logic [$clog2(ACC_DEPTH+1)-1:0] rows_i,
    output logic [PSUM_WIDTH*PE_SIZE-1:0]  out_data_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic                           busy_o,
    output logic [ERR_W-1:0]               err_o
);
    localparam int RW    = $clog2(ACC_DEPTH + 1);
    localparam int AW    = ACC_DEPTH > 1 ? $clog2(ACC_DEPTH) : 1;
    localparam int ROW_W = PSUM_WIDTH * PE_SIZE;

    logic [ROW_W-1:0]   al_row, al_row_q, sum_w;
    logic               al_valid, al_v_q, skew_err, buf_we;
    logic [PE_SIZE-1:0] ovf_w;
    acc_state_e         state_q, state_d;
    logic [RW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rows_q, rows_d;
    logic               first_q, first_d, last_q, last_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [ROW_W-1:0]   buf_q [ACC_DEPTH];

    psum_deskew #(.PE_SIZE(PE_SIZE), .PSUM_WIDTH(PSUM_WIDTH)) u_deskew (
        .clk          (clk),
        .rst_n        (rst_n),
        .psum_row_i   (psum_row_i),
        .psum_en_row_i(psum_en_row_i),
        .row_o        (al_row),
        .valid_o      (al_valid),
        .skew_err_o   (skew_err)
    );

    for (genvar k = 0; k < PE_SIZE; k++) begin : g_add
        logic [PSUM_WIDTH-1:0] a, b, s;
        assign a = buf_q[wr_ptr_q[AW-1:0]][PSUM_WIDTH*k +: PSUM_WIDTH];
        assign b = al_row_q[PSUM_WIDTH*k +: PSUM_WIDTH];
        assign s = a + b;
        assign sum_w[PSUM_WIDTH*k +: PSUM_WIDTH] = s;
        // Same-sign operands producing an opposite-sign sum is a two's-complement overflow.
        assign ovf_w[k] = (a[PSUM_WIDTH-1] == b[PSUM_WIDTH-1]) && (s[PSUM_WIDTH-1] != a[PSUM_WIDTH-1]);
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rows_d   = rows_q;
        first_d  = first_q;
        last_d   = last_q;
        buf_we   = 1'b0;
        err_d    = err_q;
        err_d[ERR_SKEW] = err_q[ERR_SKEW] | skew_err;
        err_d[ERR_DROP] = err_q[ERR_DROP] | (al_v_q && state_q != ST_ACCUM);
        case (state_q)
            ST_IDLE: if (start_i) begin
                state_d  = ST_ACCUM;
                first_d  = first_i;
                last_d   = last_i;
                rows_d   = rows_i;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end
            ST_ACCUM: if (al_v_q) begin
                buf_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + RW'(1);
                err_d[ERR_OVF] = err_q[ERR_OVF] | (!first_q && |ovf_w);
                if (wr_ptr_d == rows_q) state_d = last_q ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: if (out_ready_i) begin
                rd_ptr_d = rd_ptr_q + RW'(1);
                if (rd_ptr_d == rows_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rows_q   <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= '0;
            al_v_q   <= 1'b0;
            al_row_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rows_q   <= rows_d;
            first_q  <= first_d;
            last_q   <= last_d;
            err_q    <= err_d;
            al_v_q   <= al_valid;
            al_row_q <= al_row;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_q[wr_ptr_q[AW-1:0]] <= first_q ? al_row_q : sum_w;
    end

    assign out_valid_o = state_q == ST_DRAIN;
    assign out_data_o  = out_valid_o ? buf_q[rd_ptr_q[AW-1:0]] : '0;
    assign busy_o      = state_q != ST_IDLE;
    assign err_o       = err_q;
endmodule

// File: tb/tb_psum_accum.sv
// tb_psum_accum: randomized and directed checks of psum_accum against a tile-level reference model.
module tb_psum_accum;
    localparam int PE = 2, W = 32, D = 4, RW = $clog2(D + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [W*PE-1:0] psum_row_i;
    logic [PE-1:0]   psum_en_row_i;
    logic            start_i, first_i, last_i, out_ready_i;
    logic [RW-1:0]   rows_i;
    logic [W*PE-1:0] out_data_o;
    logic            out_valid_o, busy_o;
    logic [2:0]      err_o;

    psum_accum #(.PE_SIZE(PE), .PSUM_WIDTH(W), .ACC_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .psum_row_i(psum_row_i), .psum_en_row_i(psum_en_row_i),
        .start_i(start_i), .first_i(first_i), .last_i(last_i), .rows_i(rows_i),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0;
    logic [31:0] mbuf [D][PE];
    logic [31:0] tr0 [D], tr1 [D];
    logic [2:0]  err_exp;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input bit f, input bit l, input int r);
        start_i = 1'b1; first_i = f; last_i = l; rows_i = RW'(r);
        tick();
        start_i = 1'b0; first_i = 1'b0; last_i = 1'b0; rows_i = '0;
    endtask

    // Tile-level reference: overwrite or signed wrap-around add, overflow judged on the exact sum.
    task automatic model_tile(input bit f, input int r);
        longint s;
        for (int i = 0; i < r; i++) begin
            for (int k = 0; k < PE; k++) begin
                if (f) mbuf[i][k] = (k == 0) ? tr0[i] : tr1[i];
                else begin
                    s = longint'($signed(mbuf[i][k])) + longint'($signed((k == 0) ? tr0[i] : tr1[i]));
                    if (s > 64'sd2147483647 || s < -64'sd2147483648) err_exp[1] = 1'b1;
                    mbuf[i][k] = s[31:0];
                end
            end
        end
    endtask

    task automatic rand_rows(input int r);
        for (int i = 0; i < r; i++) begin
            tr0[i] = $urandom;
            tr1[i] = $urandom;
        end
    endtask

    task automatic send_rows(input int r, input bit b2b);
        if (b2b) begin
            for (int c = 0; c <= r; c++) begin
                psum_en_row_i = '0; psum_row_i = '0;
                if (c < r) begin psum_en_row_i[0] = 1'b1; psum_row_i[31:0] = tr0[c]; end
                if (c >= 1) begin psum_en_row_i[1] = 1'b1; psum_row_i[63:32] = tr1[c-1]; end
                tick();
            end
        end else begin
            for (int i = 0; i < r; i++) begin
                psum_en_row_i = 2'b01; psum_row_i = {32'h0, tr0[i]};
                tick();
                psum_en_row_i = 2'b10; psum_row_i = {tr1[i], 32'h0};
                tick();
            end
        end
        psum_en_row_i = '0; psum_row_i = '0;
        repeat (4) tick();
    endtask

    task automatic drain(input int r, input int maxwait);
        logic [63:0] e;
        int t;
        t = 0;
        while (!out_valid_o && t < 20) begin tick(); t++; end
        n_chk++;
        if (out_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL drain_start: out_valid_o=%b required 1", out_valid_o);
            return;
        end
        for (int i = 0; i < r; i++) begin
            repeat ($urandom_range(0, maxwait)) tick();
            e = {mbuf[i][1], mbuf[i][0]};
            n_chk++;
            if (out_valid_o !== 1'b1 || out_data_o !== e) begin
                n_fail++; $display("FAIL drain_row%0d: valid=%b data=%h required 1 %h", i, out_valid_o, out_data_o, e);
            end
            out_ready_i = 1'b1;
            tick();
            out_ready_i = 1'b0;
        end
        n_chk++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL drain_end: valid=%b busy=%b required 0 0", out_valid_o, busy_o);
        end
    endtask

    task automatic check_err(input string name);
        n_chk++;
        if (err_o !== err_exp) begin
            n_fail++; $display("FAIL %s: err_o=%b required %b", name, err_o, err_exp);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; psum_row_i = '0; psum_en_row_i = '0; start_i = 1'b0;
        first_i = 1'b0; last_i = 1'b0; rows_i = '0; out_ready_i = 1'b0; err_exp = '0;
        repeat (2) tick();
        n_chk++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || out_data_o !== 64'h0 || err_o !== 3'b0) begin
            n_fail++; $display("FAIL reset_state: busy=%b valid=%b data=%h err=%b required 0 0 0 000",
                               busy_o, out_valid_o, out_data_o, err_o);
        end
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: %b required 0", busy_o); end
    endtask

    task automatic test_single;
        tr0[0] = 32'd5; tr1[0] = 32'd7;
        start_tile(1'b1, 1'b1, 1);
        n_chk++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy: %b required 1", busy_o); end
        model_tile(1'b1, 1);
        psum_en_row_i = 2'b01; psum_row_i = {32'h0, tr0[0]};
        tick();
        psum_en_row_i = 2'b10; psum_row_i = {tr1[0], 32'h0};
        tick();
        psum_en_row_i = '0; psum_row_i = '0;
        n_chk++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_early: valid=%b required 0", out_valid_o); end
        tick();
        n_chk++;
        if (out_valid_o !== 1'b1 || out_data_o !== {32'd7, 32'd5}) begin
            n_fail++; $display("FAIL single_latency: valid=%b data=%h required 1 %h", out_valid_o, out_data_o, {32'd7, 32'd5});
        end
        drain(1, 0);
        check_err("single_err");
    endtask

    task automatic test_two_tiles;
        tr0[0] = 1; tr1[0] = 2; tr0[1] = 3; tr1[1] = 4;
        start_tile(1'b1, 1'b0, 2);
        model_tile(1'b1, 2);
        send_rows(2, 1'b1);
        n_chk++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL tileA_idle: busy=%b valid=%b required 0 0", busy_o, out_valid_o);
        end
        tr0[0] = 10; tr1[0] = 20; tr0[1] = 30; tr1[1] = 40;
        start_tile(1'b0, 1'b1, 2);
        model_tile(1'b0, 2);
        send_rows(2, 1'b0);
        n_chk++;
        if (out_data_o !== {32'd22, 32'd11}) begin
            n_fail++; $display("FAIL tileB_row0: data=%h required %h", out_data_o, {32'd22, 32'd11});
        end
        drain(2, 0);
        check_err("two_tiles_err");
    endtask

    task automatic test_backpressure;
        logic [63:0] e0, e1;
        rand_rows(2);
        tr0[0][31] = 1'b0; tr1[0][31] = 1'b0;
        start_tile(1'b1, 1'b1, 2);
        model_tile(1'b1, 2);
        send_rows(2, 1'b1);
        e0 = {mbuf[0][1], mbuf[0][0]};
        e1 = {mbuf[1][1], mbuf[1][0]};
        for (int c = 0; c < 3; c++) begin
            n_chk++;
            if (out_valid_o !== 1'b1 || out_data_o !== e0) begin
                n_fail++; $display("FAIL bp_hold%0d: valid=%b data=%h required 1 %h", c, out_valid_o, out_data_o, e0);
            end
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        n_chk++;
        if (out_valid_o !== 1'b1 || out_data_o !== e1) begin
            n_fail++; $display("FAIL bp_advance: valid=%b data=%h required 1 %h", out_valid_o, out_data_o, e1);
        end
        tick();
        n_chk++;
        if (out_data_o !== e1) begin n_fail++; $display("FAIL bp_hold_row1: data=%h required %h", out_data_o, e1); end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        n_chk++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_end: valid=%b busy=%b required 0 0", out_valid_o, busy_o);
        end
    endtask

    task automatic test_overflow;
        tr0[0] = 32'h7FFF_FFFF; tr1[0] = 32'h0000_0003;
        start_tile(1'b1, 1'b0, 1);
        model_tile(1'b1, 1);
        send_rows(1, 1'b1);
        n_chk++;
        if (err_o[1] !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: err1=%b required 0", err_o[1]); end
        tr0[0] = 32'h1; tr1[0] = 32'h4;
        start_tile(1'b0, 1'b1, 1);
        model_tile(1'b0, 1);
        send_rows(1, 1'b0);
        n_chk++;
        if (err_o[1] !== 1'b1 || out_data_o !== {32'h7, 32'h8000_0000}) begin
            n_fail++; $display("FAIL ovf_wrap: err1=%b data=%h required 1 %h", err_o[1], out_data_o, {32'h7, 32'h8000_0000});
        end
        drain(1, 1);
        check_err("ovf_err");
    endtask

    task automatic test_skew;
        start_tile(1'b1, 1'b1, 1);
        psum_en_row_i = 2'b01; psum_row_i = {32'h0, 32'hDEAD};
        tick();
        psum_en_row_i = '0; psum_row_i = '0;
        repeat (3) tick();
        err_exp[0] = 1'b1;
        n_chk++;
        if (err_o[0] !== 1'b1 || busy_o !== 1'b1 || out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL skew_flag: err0=%b busy=%b valid=%b required 1 1 0", err_o[0], busy_o, out_valid_o);
        end
        rand_rows(1);
        model_tile(1'b1, 1);
        send_rows(1, 1'b1);
        drain(1, 0);
        check_err("skew_err");
    endtask

    task automatic test_drop;
        rand_rows(1);
        send_rows(1, 1'b1);
        err_exp[2] = 1'b1;
        n_chk++;
        if (err_o[2] !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL drop_idle: err2=%b busy=%b required 1 0", err_o[2], busy_o);
        end
        check_err("drop_err");
    endtask

    task automatic test_reset_mid;
        rand_rows(2);
        start_tile(1'b1, 1'b1, 2);
        send_rows(1, 1'b1);
        n_chk++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL mid_busy: %b required 1", busy_o); end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || err_o !== 3'b0) begin
            n_fail++; $display("FAIL mid_reset: busy=%b valid=%b err=%b required 0 0 000", busy_o, out_valid_o, err_o);
        end
        tick();
        rst_n = 1'b1;
        err_exp = '0;
        tick();
        n_chk++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL mid_after: busy=%b valid=%b required 0 0", busy_o, out_valid_o);
        end
        rand_rows(3);
        start_tile(1'b1, 1'b1, 3);
        model_tile(1'b1, 3);
        send_rows(3, 1'b1);
        drain(3, 1);
        check_err("mid_err");
    endtask

    task automatic test_random;
        int nt, r;
        for (int g = 0; g < 8; g++) begin
            nt = $urandom_range(1, 3);
            r  = $urandom_range(1, D);
            for (int t = 0; t < nt; t++) begin
                rand_rows(r);
                start_tile(t == 0, t == nt - 1, r);
                model_tile(t == 0, r);
                send_rows(r, 1'($urandom_range(0, 1)));
                if (t != nt - 1) begin
                    n_chk++;
                    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rand_idle g%0d t%0d: busy=%b required 0", g, t, busy_o); end
                end
            end
            drain(r, 2);
            check_err("rand_err");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_two_tiles();
        test_backpressure();
        test_overflow();
        test_skew();
        test_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/psum_accum.md
PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 SHALL have parameters: PE_SIZE, default 2, array width in lanes; PSUM_WIDTH, default 32, bits per partial sum; ACC_DEPTH, default 4, accumulator rows.
REQ-002 SHALL have port clk  input  1  the single clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port psum_row_i  input  PSUM_WIDTH*PE_SIZE  skewed partial sums from the systolic array; lane k occupies bits [PSUM_WIDTH*(k+1)-1 : PSUM_WIDTH*k].
REQ-005 SHALL have port psum_en_row_i  input  PE_SIZE  per-lane valid, bit k for lane k.
REQ-006 SHALL have port start_i  input  1  single-cycle tile-start pulse, sampled only in IDLE.
REQ-007 SHALL have port first_i  input  1  sampled with start_i: 1 = overwrite buffer, 0 = add into buffer.
REQ-008 SHALL have port last_i  input  1  sampled with start_i: 1 = drain buffer after this tile.
REQ-009 SHALL have port rows_i  input  $clog2(ACC_DEPTH+1)  sampled with start_i: rows in tile, legal 1..ACC_DEPTH.
REQ-010 SHALL have port out_data_o  output  PSUM_WIDTH*PE_SIZE  result row, same lane packing.
REQ-011 SHALL have port out_valid_o  output  1  result row valid.
REQ-012 SHALL have port out_ready_i  input  1  downstream accepts result row.
REQ-013 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-014 SHALL have port err_o  output  3  sticky flags: [0] skew mismatch, [1] signed overflow, [2] row dropped.

Function
REQ-015 Lane k SHALL arrive k cycles after lane 0; de-skew SHALL delay lane k by PE_SIZE-1-k registers (data and enable together).
REQ-016 An aligned row SHALL be valid when all delayed enables are 1; a partial set of delayed enables SHALL set err_o[0] and the row SHALL be discarded.
REQ-017 Aligned rows SHALL be registered one more cycle, then written to buffer row wr_ptr, giving PE_SIZE+1 cycles from lane-0 arrival to buffer update.
REQ-018 States SHALL be IDLE, ACCUM, DRAIN.
REQ-019 IDLE->ACCUM on start_i; first_i, last_i and rows_i SHALL be latched and wr_ptr cleared to 0.
REQ-020 In ACCUM, each aligned row SHALL write buffer[wr_ptr] (overwrite if first, else per-lane signed add, PSUM_WIDTH wrap) and increment wr_ptr.
REQ-021 When wr_ptr reaches rows, state SHALL go to DRAIN if last, else IDLE; the final write and the transition SHALL occur in the same cycle.
REQ-022 Signed overflow on any lane add SHALL set err_o[1]; the wrapped result SHALL be stored.
REQ-023 In DRAIN, out_valid_o SHALL be 1 with out_data_o = buffer[rd_ptr]; rd_ptr SHALL advance only on out_valid_o && out_ready_i, and data SHALL be held stable otherwise.
REQ-024 After handshake of row rows-1, state SHALL return to IDLE with out_valid_o low the next cycle.
REQ-025 Aligned rows arriving in IDLE or DRAIN SHALL be dropped and SHALL set err_o[2].
REQ-026 start_i outside IDLE SHALL be ignored.
REQ-027 err_o SHALL clear only by reset.

Reset
REQ-028 On rst_n low, state SHALL be IDLE and pointers, delay lines, and err_o SHALL be 0; out_valid_o and busy_o SHALL be 0; out_data_o SHALL be 0.
REQ-029 Buffer contents need not reset; reset mid-tile SHALL abandon the tile with no output.

Structure
REQ-030 State encoding and err_o bit indices SHALL live in the shared MMU package.
REQ-031 De-skew SHALL be a sub-module psum_deskew (per-lane delay line plus alignment check); buffer and FSM SHALL stay in psum_accum.

Verification
REQ-032 PE_SIZE=2: start(first=1, last=1, rows=1); lane0=5 at t, lane1=7 at t+1 -> out_valid_o with out_data_o lane0=5, lane1=7.
REQ-033 Two tiles, rows=2: tile A (first=1) rows {1,2},{3,4}; tile B (first=0, last=1) rows {10,20},{30,40} -> outputs {11,22} then {33,44}.
REQ-034 Drain with out_ready_i held low 3 cycles -> out_data_o stable, rd_ptr unchanged, row accepted on the first ready cycle.
REQ-035 Lane0 enable alone with no lane1 enable one cycle later -> err_o[0]=1, no buffer write.
REQ-036 Add 0x7FFFFFFF + 1 on a lane -> stored 0x80000000, err_o[1]=1.
REQ-037 rst_n low during ACCUM after one row -> IDLE, busy_o=0, out_valid_o=0; a new tile then works normally.
